// File: rtl/core_scoreboard.sv
// core_scoreboard: in-order issue scoreboard between decode and execute/FPU.
// Tracks outstanding writes to the integer and FP register files. Issue is
// held while a source or destination is pending, or while the in-flight cap
// is reached. Stall cycles are counted, and a sticky flag records bad
// writebacks.
module core_scoreboard #(
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ISSUE_VALID,
    output logic             ISSUE_READY,
    input  logic [4:0]       RS1_NUM,
    input  logic [4:0]       RS2_NUM,
    input  logic             RS1_USE,
    input  logic             RS2_USE,
    input  logic             RS1_F,
    input  logic             RS2_F,
    input  logic [4:0]       RD_NUM,
    input  logic             RD_WEN,
    input  logic             FRD_WEN,
    input  logic             WB_VALID,
    input  logic [4:0]       WB_NUM,
    input  logic             FWB_VALID,
    input  logic [4:0]       FWB_NUM,
    output logic [CNT_W-1:0] PEND_CNT,
    output logic [31:0]      STALL_CNT,
    output logic             WB_ERR
);

    logic [31:0]      ipend, fpend;
    logic [31:0]      iwb_mask, fwb_mask;
    logic [31:0]      ieff, feff;
    logic [31:0]      ipend_nxt, fpend_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rs1_haz, rs2_haz, waw_i, waw_f, full;
    logic             new_dest, issue, set_i, set_f;
    logic             iwb_hit, fwb_hit, wb_bad;

    // Hazard detection against pending state with this cycle's writeback
    // already removed, so a result landing now unblocks its consumer now.
    always_comb begin
        iwb_mask = WB_VALID  ? (32'd1 << WB_NUM)  : 32'd0;
        fwb_mask = FWB_VALID ? (32'd1 << FWB_NUM) : 32'd0;
        ieff     = ipend & ~iwb_mask;
        feff     = fpend & ~fwb_mask;
        rs1_haz  = RS1_USE && (RS1_F ? feff[RS1_NUM] : ieff[RS1_NUM]);
        rs2_haz  = RS2_USE && (RS2_F ? feff[RS2_NUM] : ieff[RS2_NUM]);
        waw_i    = RD_WEN  && ieff[RD_NUM];
        waw_f    = FRD_WEN && feff[RD_NUM];
        new_dest = FRD_WEN || (RD_WEN && (RD_NUM != 5'd0));
        // No credit from a same-cycle writeback: the registered count is used.
        full     = new_dest && (PEND_CNT == CNT_W'(MAX_OUT));
        ISSUE_READY = !(rs1_haz || rs2_haz || waw_i || waw_f || full);
        issue    = ISSUE_VALID && ISSUE_READY;
        // FP destination wins if decode flags both files.
        set_f    = issue && FRD_WEN;
        set_i    = issue && RD_WEN && !FRD_WEN && (RD_NUM != 5'd0);
    end

    // Next pending vectors and count; a set on the same register as a
    // writeback overrides the clear.
    always_comb begin
        iwb_hit   = WB_VALID  && ipend[WB_NUM];
        fwb_hit   = FWB_VALID && fpend[FWB_NUM];
        wb_bad    = (WB_VALID && !iwb_hit) || (FWB_VALID && !fwb_hit);
        ipend_nxt = (ipend & ~(iwb_hit ? iwb_mask : 32'd0))
                  | (set_i ? (32'd1 << RD_NUM) : 32'd0);
        fpend_nxt = (fpend & ~(fwb_hit ? fwb_mask : 32'd0))
                  | (set_f ? (32'd1 << RD_NUM) : 32'd0);
        ipend_nxt[0] = 1'b0;
        cnt_nxt   = PEND_CNT + CNT_W'(set_i || set_f)
                  - CNT_W'(iwb_hit) - CNT_W'(fwb_hit);
    end

    // State registers: pending bits, counters and the sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ipend     <= '0;
            fpend     <= '0;
            PEND_CNT  <= '0;
            STALL_CNT <= '0;
            WB_ERR    <= 1'b0;
        end else begin
            ipend    <= ipend_nxt;
            fpend    <= fpend_nxt;
            PEND_CNT <= cnt_nxt;
            if (ISSUE_VALID && !ISSUE_READY && (STALL_CNT != 32'hFFFF_FFFF))
                STALL_CNT <= STALL_CNT + 32'd1;
            if (wb_bad)
                WB_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_scoreboard.sv
// Directed bench for core_scoreboard. The driver applies one vector per cycle
// and queues the hand-computed expectation; a monitor on the falling edge
// pops and compares ready, count, stall count and error flag.
module tb_core_scoreboard;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ISSUE_VALID = 1'b0, ISSUE_READY;
    logic [4:0]  RS1_NUM = '0, RS2_NUM = '0, RD_NUM = '0, WB_NUM = '0, FWB_NUM = '0;
    logic        RS1_USE = 1'b0, RS2_USE = 1'b0, RS1_F = 1'b0, RS2_F = 1'b0;
    logic        RD_WEN = 1'b0, FRD_WEN = 1'b0, WB_VALID = 1'b0, FWB_VALID = 1'b0;
    logic [5:0]  PEND_CNT;
    logic [31:0] STALL_CNT;
    logic        WB_ERR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        rdy;
        logic [5:0]  cnt;
        logic [31:0] stall;
        logic        err;
    } exp_t;

    exp_t q[$];

    core_scoreboard #(.MAX_OUT(8), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
        .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM),
        .RS1_USE(RS1_USE), .RS2_USE(RS2_USE),
        .RS1_F(RS1_F), .RS2_F(RS2_F),
        .RD_NUM(RD_NUM), .RD_WEN(RD_WEN), .FRD_WEN(FRD_WEN),
        .WB_VALID(WB_VALID), .WB_NUM(WB_NUM),
        .FWB_VALID(FWB_VALID), .FWB_NUM(FWB_NUM),
        .PEND_CNT(PEND_CNT), .STALL_CNT(STALL_CNT), .WB_ERR(WB_ERR)
    );

    always #5 CLK = ~CLK;

    // Monitor: compare the DUT against the queued expectation each cycle.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (ISSUE_READY !== e.rdy) begin
                errors++;
                $display("FAIL %s ready got %0b want %0b", e.name, ISSUE_READY, e.rdy);
            end
            checks++;
            if (PEND_CNT !== e.cnt) begin
                errors++;
                $display("FAIL %s pend_cnt got %0d want %0d", e.name, PEND_CNT, e.cnt);
            end
            checks++;
            if (STALL_CNT !== e.stall) begin
                errors++;
                $display("FAIL %s stall_cnt got %0d want %0d", e.name, STALL_CNT, e.stall);
            end
            checks++;
            if (WB_ERR !== e.err) begin
                errors++;
                $display("FAIL %s wb_err got %0b want %0b", e.name, WB_ERR, e.err);
            end
        end
    end

    // One cycle of stimulus; expectation covers this cycle's combinational
    // ready and the registered outputs as left by the previous edge.
    task automatic cyc(input string nm, input logic v,
                       input logic [4:0] r1, input logic u1, input logic f1,
                       input logic [4:0] rd, input logic iw, input logic fw,
                       input logic wv, input logic [4:0] wn,
                       input logic fv, input logic [4:0] fn,
                       input logic er, input int ec, input int es, input logic ee);
        exp_t e;
        @(posedge CLK);
        #1;
        ISSUE_VALID = v;  RS1_NUM = r1; RS1_USE = u1; RS1_F = f1;
        RS2_NUM = 5'd0;   RS2_USE = 1'b0; RS2_F = 1'b0;
        RD_NUM = rd;      RD_WEN = iw;  FRD_WEN = fw;
        WB_VALID = wv;    WB_NUM = wn;  FWB_VALID = fv; FWB_NUM = fn;
        e.name = nm; e.rdy = er; e.cnt = 6'(ec); e.stall = 32'(es); e.err = ee;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        ISSUE_VALID = 0; RS1_USE = 0; RD_WEN = 0; FRD_WEN = 0;
        WB_VALID = 0; FWB_VALID = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        do_reset();
        //        name        v  r1 u f  rd iw fw wv wn fv fn  rdy cnt st err
        cyc("reset_idle",     0, 0, 0,0, 0, 0,0, 0,0, 0,0,   1,  0, 0, 0);
        cyc("x0_issue",       1, 0, 0,0, 0, 1,0, 0,0, 0,0,   1,  0, 0, 0);
        cyc("x0_no_count",    0, 0, 0,0, 0, 0,0, 0,0, 0,0,   1,  0, 0, 0);
        cyc("fdiv_f3",        1, 0, 0,0, 3, 0,1, 0,0, 0,0,   1,  0, 0, 0);
        cyc("raw_f3_1",       1, 3, 1,1, 0, 0,0, 0,0, 0,0,   0,  1, 0, 0);
        cyc("raw_f3_2",       1, 3, 1,1, 0, 0,0, 0,0, 0,0,   0,  1, 1, 0);
        cyc("raw_f3_3",       1, 3, 1,1, 0, 0,0, 0,0, 0,0,   0,  1, 2, 0);
        cyc("raw_f3_4",       1, 3, 1,1, 0, 0,0, 0,0, 0,0,   0,  1, 3, 0);
        cyc("fwb_unblock",    1, 3, 1,1, 0, 0,0, 0,0, 1,3,   1,  1, 4, 0);
        cyc("after_fwb",      0, 0, 0,0, 0, 0,0, 0,0, 0,0,   1,  0, 4, 0);
        cyc("issue_x5",       1, 0, 0,0, 5, 1,0, 0,0, 0,0,   1,  0, 4, 0);
        cyc("x5_fp_src",      1, 5, 1,1, 0, 0,0, 0,0, 0,0,   1,  1, 4, 0);
        cyc("x5_int_src",     1, 5, 1,0, 0, 0,0, 0,0, 0,0,   0,  1, 4, 0);
        cyc("wb_x5",          0, 0, 0,0, 0, 0,0, 1,5, 0,0,   1,  1, 5, 0);
        for (int i = 1; i <= 8; i++)
            cyc("fill",       1, 0, 0,0, 5'(i), 1,0, 0,0, 0,0, 1, i-1, 5, 0);
        cyc("full_nodest",    1,20, 1,0, 0, 0,0, 0,0, 0,0,   1,  8, 5, 0);
        cyc("full_stall_wb",  1, 0, 0,0, 9, 1,0, 1,1, 0,0,   0,  8, 5, 0);
        cyc("same_cyc_x7",    1, 0, 0,0, 7, 1,0, 1,7, 0,0,   1,  7, 6, 0);
        cyc("x7_still_pend",  1, 7, 1,0, 0, 0,0, 0,0, 0,0,   0,  7, 6, 0);
        cyc("wb_x9_bad",      0, 0, 0,0, 0, 0,0, 1,9, 0,0,   1,  7, 7, 0);
        cyc("err_set",        0, 0, 0,0, 0, 0,0, 0,0, 0,0,   1,  7, 7, 1);
        cyc("err_sticky",     0, 0, 0,0, 0, 0,0, 0,0, 0,0,   1,  7, 7, 1);
        do_reset();
        cyc("rst_clear",      0, 0, 0,0, 0, 0,0, 0,0, 0,0,   1,  0, 0, 0);
        cyc("rst_x7_free",    1, 7, 1,0, 0, 0,0, 0,0, 0,0,   1,  0, 0, 0);
        cyc("both_wen_f4",    1, 0, 0,0, 4, 1,1, 0,0, 0,0,   1,  0, 0, 0);
        cyc("x4_not_set",     1, 4, 1,0, 0, 0,0, 0,0, 0,0,   1,  1, 0, 0);
        cyc("f4_set",         1, 4, 1,1, 0, 0,0, 0,0, 0,0,   0,  1, 0, 0);
        cyc("final_idle",     0, 0, 0,0, 0, 0,0, 0,0, 0,0,   1,  1, 1, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_scoreboard.md
# core_scoreboard

In-order issue scoreboard placed between the decode stage and the execute/FPU stage of the core. It tracks outstanding writes to the 32 integer and 32 FP registers, caused by multi-cycle ops such as loads, FDIV and FSQRT. It holds issue while a source or destination register is pending, and releases registers as results write back. It also caps the number of in-flight writes and counts stall cycles.

## Interface
Parameters:
- MAX_OUT, 8, maximum outstanding register writes (1..63)
- CNT_W, 6, width of outstanding counter; must hold MAX_OUT

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- ISSUE_VALID  in  1  decoded instruction present this cycle
- ISSUE_READY  out  1  combinational; instruction may issue this cycle
- RS1_NUM / RS2_NUM  in  5  source register numbers
- RS1_USE / RS2_USE  in  1  source is actually read
- RS1_F / RS2_F  in  1  source is in the FP file (1) or the integer file (0)
- RD_NUM  in  5  destination register number
- RD_WEN  in  1  instruction writes integer rd (decode RDVALID)
- FRD_WEN  in  1  instruction writes FP rd (decode FRDVALID)
- WB_VALID  in  1  integer writeback this cycle
- WB_NUM  in  5  integer writeback register
- FWB_VALID  in  1  FP writeback this cycle
- FWB_NUM  in  5  FP writeback register
- PEND_CNT  out  CNT_W  outstanding write count (registered)
- STALL_CNT  out  32  saturating count of ISSUE_VALID && !ISSUE_READY cycles
- WB_ERR  out  1  sticky; writeback to a non-pending register

## Operation
- State: IPEND[31:0], FPEND[31:0], PEND_CNT, STALL_CNT, WB_ERR.
- IPEND[0] is hardwired 0. An integer x0 never creates a hazard, and RD_WEN with RD_NUM=0 sets nothing and does not increment the count.
- Effective pending vectors, cleared by this cycle's writeback:
  - IEFF = IPEND & ~(WB_VALID ? onehot(WB_NUM) : 0)
  - FEFF is formed the same way from FPEND, FWB_VALID and FWB_NUM.
- Hazard conditions; any one makes a hazard:
  - RSx_USE and the selected EFF[RSx_NUM] is set (RAW).
  - RD_WEN && IEFF[RD_NUM] (WAW).
  - FRD_WEN && FEFF[RD_NUM] (WAW).
  - Full: new_dest && PEND_CNT == MAX_OUT, where new_dest = FRD_WEN || (RD_WEN && RD_NUM != 0). Full is evaluated on the registered count, with no same-cycle credit from writeback.
- ISSUE_READY = !hazard. It is independent of ISSUE_VALID.
- issue = ISSUE_VALID && ISSUE_READY. On issue, set the destination pending bit.
- RD_WEN and FRD_WEN both set (illegal): FRD_WEN wins, integer bit not set, count +1.
- Writeback:
  - A writeback clears its bit if the bit is set, and decrements the count.
  - Writeback to a non-pending register: no state change except WB_ERR <= 1.
- Same-cycle issue and writeback of the same register: set wins. Bit stays 1, count changes by +1 and -1 (net 0).
- PEND_CNT next = PEND_CNT + issue_inc - int_wb_dec - fp_wb_dec, giving a change in the range -2..+1.
- STALL_CNT increments when ISSUE_VALID && !ISSUE_READY, and saturates at 0xFFFFFFFF.

## Timing
- Reset (RST=1 at an edge): IPEND=0, FPEND=0, PEND_CNT=0, STALL_CNT=0, WB_ERR=0.
  - ISSUE_READY is therefore 1 in the cycle after reset.
  - Reset mid-operation discards all pending state; writebacks arriving later raise WB_ERR.
- ISSUE_READY is combinational from inputs and registered state, with zero latency.
- A writeback in cycle N unblocks a dependent issue in the same cycle N.
- An issue in cycle N blocks dependents from cycle N+1.
- PEND_CNT, STALL_CNT and WB_ERR update one cycle after the causing event.

## Test plan
- Reset then idle:
  - PEND_CNT=0, ISSUE_READY=1, STALL_CNT=0, WB_ERR=0.
  - Issue RD_WEN RD_NUM=0 → PEND_CNT stays 0.
- Issue FDIV f3 (FRD_WEN, RD_NUM=3), then an op with RS1_F=1, RS1_NUM=3 for 4 cycles:
  - ISSUE_READY=0 and STALL_CNT=4.
  - FWB_VALID with FWB_NUM=3 in cycle 5 → ISSUE_READY=1 the same cycle; the issue proceeds.
- Integer x5 pending, with RS1_NUM=5 and RS1_F=1 → no hazard (files are distinct). With RS1_F=0 → hazard.
- MAX_OUT=8: issue writes to x1..x8 → PEND_CNT=8.
  - Next issue with RD_WEN=1 stalls, even with WB_VALID (no same-cycle credit).
  - An instruction with no destination and no hazarded sources issues.
- Same cycle: issue writing x7 and WB_VALID for x7 (already pending) → IPEND[7] stays 1, PEND_CNT unchanged.
- WB_VALID for x9 (not pending) → WB_ERR=1 next cycle and stays 1; PEND_CNT unchanged. Assert RST → WB_ERR=0.
